// File: rtl/rca_lsq_adapter_pkg.sv
// Shared configuration for the OU-to-core-LSQ adapter.
// It holds the datapath width, the adapter sizing defaults, the load/store
// fn3 size codes, and the request record that the request FIFO stores.
package rca_lsq_adapter_pkg;

  localparam int XLEN                  = 32;
  localparam int LSQ_ADAPTER_DEPTH     = 4;
  localparam int LSQ_ADAPTER_MAX_LOADS = 2;

  // Access size/sign codes carried in fn3.
  localparam logic [2:0] LS_B_FN3  = 3'b000;
  localparam logic [2:0] LS_H_FN3  = 3'b001;
  localparam logic [2:0] LS_W_FN3  = 3'b010;
  localparam logic [2:0] LS_BU_FN3 = 3'b100;
  localparam logic [2:0] LS_HU_FN3 = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
  } rca_lsq_req_t;

endpackage

// File: rtl/rca_lsq_adapter_if.sv
// Request/return bus between the adapter and the core load-store queue.
//   master : the adapter side. It offers the head request (core_*,
//            core_req_valid) and receives core_req_ready plus the load returns.
//   slave  : the core LSQ side.
interface rca_lsq_adapter_if;
  import rca_lsq_adapter_pkg::*;

  logic [XLEN-1:0] core_addr;
  logic [XLEN-1:0] core_data;
  logic [2:0]      core_fn3;
  logic            core_load;
  logic            core_store;
  logic            core_req_valid;
  logic            core_req_ready;
  logic [XLEN-1:0] core_load_data;
  logic            core_load_valid;

  modport master (
    output core_addr, core_data, core_fn3, core_load, core_store, core_req_valid,
    input  core_req_ready, core_load_data, core_load_valid
  );

  modport slave (
    input  core_addr, core_data, core_fn3, core_load, core_store, core_req_valid,
    output core_req_ready, core_load_data, core_load_valid
  );

endinterface

// File: rtl/rca_lsq_req_fifo.sv
// In-order request FIFO of rca_lsq_req_t entries.
// Ports:
//   clk, rst : clock and synchronous active-low reset.
//   push     : write push_req at the tail. It is ignored while full.
//   pop      : retire the head entry. It is ignored while empty.
//   head_req : the entry currently at the head (registered storage).
//   full, empty, count : occupancy, all derived from registered state.
// DEPTH must be a power of two so that the pointers wrap naturally.
module rca_lsq_req_fifo
  import rca_lsq_adapter_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  rca_lsq_req_t push_req,
  output rca_lsq_req_t head_req,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  rca_lsq_req_t  mem_r [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full     = (count_r == DEPTH_CNT);
  assign empty    = (count_r == {CW{1'b0}});
  assign count    = count_r;
  assign head_req = mem_r[head_r];

  // Internal guards, so a caller slip can never corrupt the pointers.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Storage, pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_r   <= '{default: '0};
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[tail_r] <= push_req;
        tail_r        <= tail_r + 1'b1;
      end
      if (pop_ok_s) begin
        head_r <= head_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rca_lsq_adapter.sv
// Adapter between the reconfigurable load/store OUs and the core LSQ.
// It queues OU requests in order and offers the head request to the core LSQ.
// It limits the number of loads in flight to MAX_LOADS, and it returns load
// data to the OU as a registered single-cycle completion pulse.
// Ports:
//   clk, rst            : clock and synchronous active-low reset.
//   addr/data/fn3/load/store/new_request : OU request side.
//   lsq_full            : back-pressure to the OU (FIFO full).
//   load_data/load_complete : registered load return to the OU.
//   bus                 : core LSQ request/return interface (master side).
//   err_malformed       : sticky, a request had load == store.
//   err_unexpected_load : sticky, a return arrived with nothing outstanding.
module rca_lsq_adapter
  import rca_lsq_adapter_pkg::*;
#(
  parameter int  DEPTH     = LSQ_ADAPTER_DEPTH,
  parameter int  MAX_LOADS = LSQ_ADAPTER_MAX_LOADS,
  localparam int CW        = $clog2(DEPTH) + 1,
  localparam int OW        = $clog2(MAX_LOADS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     addr,
  input  logic [XLEN-1:0]     data,
  input  logic [2:0]          fn3,
  input  logic                load,
  input  logic                store,
  input  logic                new_request,
  output logic                lsq_full,
  output logic [XLEN-1:0]     load_data,
  output logic                load_complete,
  rca_lsq_adapter_if.master   bus,
  output logic                err_malformed,
  output logic                err_unexpected_load
);

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [OW-1:0] MAX_OUT   = OW'(MAX_LOADS);

  rca_lsq_req_t  push_req_s;
  rca_lsq_req_t  head_req_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic          accept_s;
  logic          push_s;
  logic          malformed_s;
  logic          core_valid_s;
  logic          pop_s;
  logic          load_issue_s;
  logic          unexpected_s;
  logic [OW-1:0] outstanding_r;
  logic [OW-1:0] out_next_s;
  logic [XLEN-1:0] load_data_r;
  logic          load_complete_r;
  logic          err_malformed_r;
  logic          err_unexpected_r;

  rca_lsq_req_fifo #(.DEPTH(DEPTH)) u_req_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .pop      (pop_s),
    .push_req (push_req_s),
    .head_req (head_req_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s)
  );

  assign push_req_s = '{addr: addr, data: data, fn3: fn3, load: load, store: store};

  // Request acceptance, head offer and in-flight load accounting.
  always_comb begin
    accept_s     = new_request && !fifo_full_s;
    push_s       = accept_s && (load ^ store);
    malformed_s  = accept_s && (load == store);
    // A head load held back by the throttle also stalls everything behind it.
    core_valid_s = !fifo_empty_s && !(head_req_s.load && (outstanding_r == MAX_OUT));
    pop_s        = core_valid_s && bus.core_req_ready;
    load_issue_s = pop_s && head_req_s.load;
    unexpected_s = bus.core_load_valid && !load_issue_s && (outstanding_r == {OW{1'b0}});
    case ({load_issue_s, bus.core_load_valid})
      2'b10: out_next_s = outstanding_r + 1'b1;
      2'b01: begin
        if (outstanding_r != {OW{1'b0}}) begin
          out_next_s = outstanding_r - 1'b1;
        end else begin
          out_next_s = outstanding_r;
        end
      end
      default: out_next_s = outstanding_r;
    endcase
  end

  // Outstanding counter, load return register and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      outstanding_r    <= '0;
      load_data_r      <= '0;
      load_complete_r  <= 1'b0;
      err_malformed_r  <= 1'b0;
      err_unexpected_r <= 1'b0;
    end else begin
      outstanding_r   <= out_next_s;
      // A return that matches no issued load is flagged, not forwarded.
      load_complete_r <= bus.core_load_valid && !unexpected_s;
      if (bus.core_load_valid && !unexpected_s) begin
        load_data_r <= bus.core_load_data;
      end
      if (malformed_s) begin
        err_malformed_r <= 1'b1;
      end
      if (unexpected_s) begin
        err_unexpected_r <= 1'b1;
      end
    end
  end

  assign lsq_full            = (fifo_count_s == DEPTH_CNT);
  assign load_data           = load_data_r;
  assign load_complete       = load_complete_r;
  assign err_malformed       = err_malformed_r;
  assign err_unexpected_load = err_unexpected_r;

  assign bus.core_addr      = head_req_s.addr;
  assign bus.core_data      = head_req_s.data;
  assign bus.core_fn3       = head_req_s.fn3;
  assign bus.core_load      = head_req_s.load;
  assign bus.core_store     = head_req_s.store;
  assign bus.core_req_valid = core_valid_s;

endmodule

// File: tb/tb_rca_lsq_adapter.sv
// Directed bench for rca_lsq_adapter (DEPTH=4, MAX_LOADS=2).
module tb_rca_lsq_adapter;
  import rca_lsq_adapter_pkg::*;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] data;
  logic [2:0]      fn3;
  logic            load;
  logic            store;
  logic            new_request;
  logic            lsq_full;
  logic [XLEN-1:0] load_data;
  logic            load_complete;
  logic            err_malformed;
  logic            err_unexpected_load;

  int checks;
  int failures;

  rca_lsq_adapter_if lsq_bus ();

  rca_lsq_adapter #(.DEPTH(4), .MAX_LOADS(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .addr                (addr),
    .data                (data),
    .fn3                 (fn3),
    .load                (load),
    .store               (store),
    .new_request         (new_request),
    .lsq_full            (lsq_full),
    .load_data           (load_data),
    .load_complete       (load_complete),
    .bus                 (lsq_bus),
    .err_malformed       (err_malformed),
    .err_unexpected_load (err_unexpected_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                     input logic ld, input logic st);
    new_request = 1'b1;
    addr = a;
    data = d;
    fn3 = f;
    load = ld;
    store = st;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    addr = 32'h0;
    data = 32'h0;
    fn3 = 3'b000;
    load = 1'b0;
    store = 1'b0;
    new_request = 1'b0;
    lsq_bus.core_req_ready = 1'b0;
    lsq_bus.core_load_data = 32'h0;
    lsq_bus.core_load_valid = 1'b0;
    tick();
    tick();
    check("rst_lsq_full", {31'd0, lsq_full}, 32'd0);
    check("rst_req_valid", {31'd0, lsq_bus.core_req_valid}, 32'd0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_load_complete", {31'd0, load_complete}, 32'd0);
    check("rst_err_malformed", {31'd0, err_malformed}, 32'd0);
    check("rst_err_unexp", {31'd0, err_unexpected_load}, 32'd0);
    rst = 1'b1;

    // Store streaming: fill with 4 byte stores while the core is not ready.
    for (int i = 0; i < 4; i++) begin
      req(32'h100 + i, 32'hAA + i, LS_B_FN3, 1'b0, 1'b1);
      tick();
      if (i == 0) begin
        check("st_first_valid", {31'd0, lsq_bus.core_req_valid}, 32'd1);
        check("st_first_addr", lsq_bus.core_addr, 32'h100);
      end
    end
    check("st_full_after4", {31'd0, lsq_full}, 32'd1);
    req(32'h200, 32'hEE, LS_B_FN3, 1'b0, 1'b1);
    tick();
    check("st_full_5th", {31'd0, lsq_full}, 32'd1);
    check("st_head_after5th", lsq_bus.core_addr, 32'h100);
    new_request = 1'b0;
    lsq_bus.core_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("st_drain_valid", {31'd0, lsq_bus.core_req_valid}, 32'd1);
      check("st_drain_addr", lsq_bus.core_addr, 32'h100 + i);
      check("st_drain_data", lsq_bus.core_data, 32'hAA + i);
      check("st_drain_store", {31'd0, lsq_bus.core_store}, 32'd1);
      tick();
      if (i == 0) begin
        check("st_full_drop", {31'd0, lsq_full}, 32'd0);
      end
    end
    check("st_empty_valid", {31'd0, lsq_bus.core_req_valid}, 32'd0);

    // Load throttle: three word loads, no returns, only two may issue.
    lsq_bus.core_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(32'h300 + i, 32'h0, LS_W_FN3, 1'b1, 1'b0);
      tick();
    end
    new_request = 1'b0;
    lsq_bus.core_req_ready = 1'b1;
    tick();
    tick();
    check("ld_blocked_valid", {31'd0, lsq_bus.core_req_valid}, 32'd0);
    check("ld_blocked_addr", lsq_bus.core_addr, 32'h302);
    check("ld_blocked_isload", {31'd0, lsq_bus.core_load}, 32'd1);
    tick();
    check("ld_still_blocked", {31'd0, lsq_bus.core_req_valid}, 32'd0);
    lsq_bus.core_load_valid = 1'b1;
    lsq_bus.core_load_data = 32'hDEADBEEF;
    tick();
    lsq_bus.core_load_valid = 1'b0;
    check("ld_ret_complete", {31'd0, load_complete}, 32'd1);
    check("ld_ret_data", load_data, 32'hDEADBEEF);
    check("ld_third_valid", {31'd0, lsq_bus.core_req_valid}, 32'd1);
    check("ld_third_addr", lsq_bus.core_addr, 32'h302);
    tick();
    check("ld_pulse_single", {31'd0, load_complete}, 32'd0);
    check("ld_data_hold", load_data, 32'hDEADBEEF);
    check("ld_queue_empty", {31'd0, lsq_bus.core_req_valid}, 32'd0);

    // Simultaneous issue and return: two loads are outstanding at this point.
    req(32'h400, 32'h0, LS_W_FN3, 1'b1, 1'b0);
    lsq_bus.core_load_valid = 1'b1;
    lsq_bus.core_load_data = 32'h11111111;
    tick();
    new_request = 1'b0;
    check("sim_ret1_data", load_data, 32'h11111111);
    check("sim_head_valid", {31'd0, lsq_bus.core_req_valid}, 32'd1);
    lsq_bus.core_load_data = 32'h22222222;
    tick();
    lsq_bus.core_load_valid = 1'b0;
    check("sim_ret2_complete", {31'd0, load_complete}, 32'd1);
    check("sim_ret2_data", load_data, 32'h22222222);
    check("sim_no_err", {31'd0, err_unexpected_load}, 32'd0);
    req(32'h401, 32'h0, LS_W_FN3, 1'b1, 1'b0);
    tick();
    check("sim_401_valid", {31'd0, lsq_bus.core_req_valid}, 32'd1);
    req(32'h402, 32'h0, LS_W_FN3, 1'b1, 1'b0);
    tick();
    new_request = 1'b0;
    // Only the counter left unchanged by the simultaneous cycle blocks 0x402 here.
    check("sim_cnt_blocks", {31'd0, lsq_bus.core_req_valid}, 32'd0);
    check("sim_cnt_addr", lsq_bus.core_addr, 32'h402);
    lsq_bus.core_load_valid = 1'b1;
    lsq_bus.core_load_data = 32'h33333333;
    tick();
    check("b2b_ret1_data", load_data, 32'h33333333);
    check("b2b_head_valid", {31'd0, lsq_bus.core_req_valid}, 32'd1);
    lsq_bus.core_load_data = 32'h44444444;
    tick();
    check("b2b_ret2_complete", {31'd0, load_complete}, 32'd1);
    check("b2b_ret2_data", load_data, 32'h44444444);
    lsq_bus.core_load_data = 32'h55555555;
    tick();
    check("b2b_ret3_complete", {31'd0, load_complete}, 32'd1);
    check("b2b_ret3_data", load_data, 32'h55555555);
    lsq_bus.core_load_valid = 1'b0;
    tick();
    check("b2b_idle_complete", {31'd0, load_complete}, 32'd0);
    check("b2b_no_err", {31'd0, err_unexpected_load}, 32'd0);

    // Malformed request is dropped and the sticky flag is raised.
    lsq_bus.core_req_ready = 1'b0;
    req(32'h500, 32'h1, LS_W_FN3, 1'b0, 1'b1);
    tick();
    req(32'h600, 32'h2, LS_W_FN3, 1'b1, 1'b1);
    tick();
    check("mal_err", {31'd0, err_malformed}, 32'd1);
    check("mal_head", lsq_bus.core_addr, 32'h500);
    req(32'h501, 32'h3, LS_W_FN3, 1'b0, 1'b1);
    tick();
    req(32'h502, 32'h4, LS_W_FN3, 1'b0, 1'b1);
    tick();
    check("mal_count3_notfull", {31'd0, lsq_full}, 32'd0);
    req(32'h503, 32'h5, LS_W_FN3, 1'b0, 1'b1);
    tick();
    check("mal_count4_full", {31'd0, lsq_full}, 32'd1);
    new_request = 1'b0;
    lsq_bus.core_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("mal_drain_addr", lsq_bus.core_addr, 32'h500 + i);
      tick();
    end
    check("mal_drained", {31'd0, lsq_bus.core_req_valid}, 32'd0);
    check("mal_err_sticky", {31'd0, err_malformed}, 32'd1);

    // Unexpected return while no load is outstanding.
    lsq_bus.core_load_valid = 1'b1;
    lsq_bus.core_load_data = 32'h66666666;
    tick();
    lsq_bus.core_load_valid = 1'b0;
    check("unx_err", {31'd0, err_unexpected_load}, 32'd1);
    check("unx_no_complete", {31'd0, load_complete}, 32'd0);
    check("unx_data_hold", load_data, 32'h55555555);
    tick();
    check("unx_err_sticky", {31'd0, err_unexpected_load}, 32'd1);

    // Reset mid-operation: 3 entries queued, 1 load in flight.
    lsq_bus.core_req_ready = 1'b0;
    req(32'h700, 32'h0, LS_W_FN3, 1'b1, 1'b0);
    tick();
    for (int i = 1; i < 4; i++) begin
      req(32'h700 + i, 32'h10 + i, LS_W_FN3, 1'b0, 1'b1);
      tick();
    end
    new_request = 1'b0;
    lsq_bus.core_req_ready = 1'b1;
    tick();
    lsq_bus.core_req_ready = 1'b0;
    check("mid_head", lsq_bus.core_addr, 32'h701);
    check("mid_notfull", {31'd0, lsq_full}, 32'd0);
    rst = 1'b0;
    tick();
    check("mrst_lsq_full", {31'd0, lsq_full}, 32'd0);
    check("mrst_req_valid", {31'd0, lsq_bus.core_req_valid}, 32'd0);
    check("mrst_load_data", load_data, 32'h0);
    check("mrst_load_complete", {31'd0, load_complete}, 32'd0);
    check("mrst_err_malformed", {31'd0, err_malformed}, 32'd0);
    check("mrst_err_unexp", {31'd0, err_unexpected_load}, 32'd0);
    rst = 1'b1;
    lsq_bus.core_load_valid = 1'b1;
    lsq_bus.core_load_data = 32'h77777777;
    tick();
    lsq_bus.core_load_valid = 1'b0;
    check("stale_err", {31'd0, err_unexpected_load}, 32'd1);
    check("stale_no_complete", {31'd0, load_complete}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
